qft_crot_sequencer: RTL
=======================

# qft_crot_sequencer

Upstream control stage for the pipelined controlled-rotation gate in the QFT datapath. For every control/target qubit pair it streams the affected state-vector amplitudes from the amplitude memory into the CROT gate, supplying the matching angle theta = pi/2^(k-j). It also writes the rotated amplitudes back to the same addresses once the gate's fixed latency has elapsed. Hadamard stages are outside this block; it handles only the controlled-phase passes.

## Interface
- N_QUBITS, default 3: number of qubits. The state vector holds 2^N_QUBITS amplitudes.
- CROT_LAT, default 11: CROT gate latency, from inputs sampled to outputs valid.
- PI_FX, default pi in `TOTAL_WIDTH`/`FRAC_WIDTH` fixed point: value of pi.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to run all rotation passes. Ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write-back.
- mem_rd_en  out  1  amplitude read request.
- mem_rd_addr  out  N_QUBITS  read index.
- mem_rd_r, mem_rd_i  in  `TOTAL_WIDTH` signed  read data, valid 1 cycle after mem_rd_en.
- crot_in_r, crot_in_i  out  `TOTAL_WIDTH` signed  combinational pass-through of mem_rd_r/mem_rd_i.
- crot_theta  out  `TOTAL_WIDTH` signed  registered angle, aligned with crot_in_*.
- crot_out_r, crot_out_i  in  `TOTAL_WIDTH` signed  rotated amplitude from the gate.
- mem_wr_en  out  1  write-back strobe.
- mem_wr_addr  out  N_QUBITS  write index.
- mem_wr_r, mem_wr_i  out  `TOTAL_WIDTH` signed  combinational pass-through of crot_out_r/crot_out_i.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- Passes are pairs (j,k) with 0<=j<k<N_QUBITS. j is the outer loop and k the inner loop, both ascending. There are N(N-1)/2 passes.
- IDLE + start:
  - If N_QUBITS>=2: load j=0, k=1, index counter i=0, and go to ISSUE.
  - If N_QUBITS==1: go straight to DONE.
- ISSUE: one index per cycle, i = 0 .. 2^N-1.
  - If bit j and bit k of i are both 1: assert mem_rd_en, drive mem_rd_addr=i, register crot_theta <= PI_FX >>> (k-j) (arithmetic shift), and push tag {valid=1, addr=i} into the delay line.
  - Otherwise push {valid=0}.
  - After i=2^N-1, go to DRAIN.
- Delay line: CROT_LAT+1 stages of {valid, addr}. The extra stage covers the memory read cycle.
  - When a valid tag reaches the last stage, assert mem_wr_en with mem_wr_addr=tag.addr and mem_wr_*=crot_out_*.
- An in-flight counter increments on each issued read and decrements on each write. If both happen in the same cycle, it is unchanged.
- DRAIN: wait until the in-flight count is 0, then:
  - advance (j,k): k+1; if k wraps past N-1, set j+1 and k=j+2;
  - if pairs remain, go to ISSUE with i=0;
  - otherwise go to DONE.
- The drain barrier guarantees a pass never reads an address whose previous-pass result is still in flight.
- DONE: pulse done for 1 cycle, then go to IDLE.
- crot_theta holds its last value when no read is issued.

## Timing
- Reset values:
  - busy=0, done=0, mem_rd_en=0, mem_wr_en=0;
  - mem_rd_addr=0, crot_theta=0;
  - FSM in IDLE, delay line all invalid, in-flight count 0.
  - crot_in_* and mem_wr_* follow their inputs.
- Read issued in cycle t:
  - mem_rd_r/mem_rd_i and crot_theta are valid in cycle t+1;
  - the CROT gate samples them at the end of t+1;
  - crot_out_* and mem_wr_en are valid in cycle t+1+CROT_LAT, which is t+12 by default.
- Back-to-back reads at 1 per cycle are allowed. Write-backs appear in the same order and with the same spacing as the reads.
- In the cycle of the last write of a pass, the count goes to 0 and DRAIN exits. The next ISSUE cycle (or DONE) follows on the next edge.
- Pass length: 2^N ISSUE cycles, then DRAIN. DRAIN ends with the final write at (last read cycle + 12).
- start is accepted in IDLE. busy rises 1 cycle after start and falls in the same cycle done pulses.
- start pulses while busy are dropped and have no effect.
- rst_n asserted mid-run:
  - immediately clears all state and outputs;
  - no further mem_wr_en; in-flight results are discarded;
  - the memory contents are left as partially rotated.

## Test plan
- N=3, start once → passes (0,1), (0,2), (1,2) in that order:
  - reads at indices {3,7}, then {5,7}, then {6,7};
  - crot_theta = PI_FX>>>1, PI_FX>>>2, PI_FX>>>1 respectively;
  - done pulses exactly once.
- Latency check: read of addr 3 in cycle t → mem_wr_en=1, mem_wr_addr=3 in cycle t+12, and crot_out_* are forwarded unmodified.
- Barrier: during pass (0,2), no read of index 7 occurs before the pass (0,1) write of index 7 has happened. The in-flight count never exceeds 2 (for N=3).
- start pulsed again while busy=1 → ignored; total write count is 6 and there is a single done pulse.
- rst_n pulsed low 5 cycles after the first read → all outputs drop to 0 asynchronously. No mem_wr_en appears afterwards. A fresh start then completes normally.
- Parameter sweep:
  - N_QUBITS=1: start leads to done 2 cycles later with no reads.
  - N_QUBITS=4: 6 passes with 4 writes each, 24 writes total.

Source files
------------

// File: rtl/qft_crot_sequencer_if.sv
// Bus bundle between the QFT controlled-rotation sequencer and its amplitude
// memory / CROT gate neighbours. The sequencer side uses the master modport.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 13
`endif

interface qft_crot_sequencer_if #(
    parameter int N_QUBITS = 3
) ();
    logic                              start;
    logic                              busy;
    logic                              done;
    logic                              mem_rd_en;
    logic [N_QUBITS-1:0]               mem_rd_addr;
    logic signed [`TOTAL_WIDTH-1:0]    mem_rd_r;
    logic signed [`TOTAL_WIDTH-1:0]    mem_rd_i;
    logic signed [`TOTAL_WIDTH-1:0]    crot_in_r;
    logic signed [`TOTAL_WIDTH-1:0]    crot_in_i;
    logic signed [`TOTAL_WIDTH-1:0]    crot_theta;
    logic signed [`TOTAL_WIDTH-1:0]    crot_out_r;
    logic signed [`TOTAL_WIDTH-1:0]    crot_out_i;
    logic                              mem_wr_en;
    logic [N_QUBITS-1:0]               mem_wr_addr;
    logic signed [`TOTAL_WIDTH-1:0]    mem_wr_r;
    logic signed [`TOTAL_WIDTH-1:0]    mem_wr_i;

    modport master (
        input  start,
        output busy, done,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_r, mem_rd_i,
        output crot_in_r, crot_in_i, crot_theta,
        input  crot_out_r, crot_out_i,
        output mem_wr_en, mem_wr_addr, mem_wr_r, mem_wr_i
    );

    modport slave (
        output start,
        input  busy, done,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_r, mem_rd_i,
        input  crot_in_r, crot_in_i, crot_theta,
        output crot_out_r, crot_out_i,
        input  mem_wr_en, mem_wr_addr, mem_wr_r, mem_wr_i
    );
endinterface

// File: rtl/qft_crot_sequencer.sv
// Controlled-phase pass sequencer for the QFT datapath: walks every (j,k)
// qubit pair, streams the amplitudes with bits j and k set through the CROT
// gate with theta = pi/2^(k-j), and writes the results back after the gate
// latency. A drain barrier between passes keeps read-after-write ordering.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 13
`endif

module qft_crot_sequencer #(
    parameter int N_QUBITS = 3,
    parameter int CROT_LAT = 11,
    // round(pi * 2^FRAC_WIDTH) for the default 16/13 fixed-point format
    parameter logic signed [`TOTAL_WIDTH-1:0] PI_FX = `TOTAL_WIDTH'(25736)
) (
    input logic                  clk,
    input logic                  rst_n,
    qft_crot_sequencer_if.master bus
);
    localparam int TW = `TOTAL_WIDTH;
    // pair counters must hold k = j+2 = N_QUBITS when the last pair wraps
    localparam int QW = $clog2(N_QUBITS + 2);
    localparam int CW = $clog2(CROT_LAT + 3);
    localparam logic [QW-1:0] LAST_Q = QW'(N_QUBITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_nx;
    logic [N_QUBITS-1:0]        r_i;
    logic [QW-1:0]              r_j;
    logic [QW-1:0]              r_k;
    logic signed [TW-1:0]       r_theta;
    logic [CROT_LAT:0]          r_dl_vld;
    logic [N_QUBITS-1:0]        r_dl_addr [0:CROT_LAT];
    logic [CW-1:0]              r_cnt;
    logic                       r_busy;
    logic                       r_done;

    logic [N_QUBITS-1:0]        w_mask;
    logic                       w_hit;
    logic                       w_rd_fire;
    logic                       w_wr_fire;
    logic [CW-1:0]              w_cnt_nx;
    logic [QW-1:0]              w_k_inc;
    logic [QW-1:0]              w_j_nx;
    logic [QW-1:0]              w_k_nx;
    logic                       w_more;
    logic                       w_load_first;
    logic                       w_next_pass;
    logic                       w_busy_set;

    // pi / 2^(k-j); arithmetic shift keeps the sign of the angle
    function automatic logic signed [TW-1:0] theta_for(input logic [QW-1:0] j,
                                                       input logic [QW-1:0] k);
        theta_for = PI_FX >>> (k - j);
    endfunction

    assign w_mask    = (N_QUBITS'(1) << r_j) | (N_QUBITS'(1) << r_k);
    assign w_hit     = ((r_i & w_mask) == w_mask);
    assign w_wr_fire = r_dl_vld[CROT_LAT];
    assign w_cnt_nx  = r_cnt + CW'(w_rd_fire) - CW'(w_wr_fire);

    // next (j,k) pair: k steps inner, j outer; k restarts at j+2 on wrap
    always_comb begin
        w_k_inc = r_k + QW'(1);
        if (w_k_inc > LAST_Q) begin
            w_j_nx = r_j + QW'(1);
            w_k_nx = r_j + QW'(2);
        end else begin
            w_j_nx = r_j;
            w_k_nx = w_k_inc;
        end
        w_more = (w_k_nx <= LAST_Q);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // FSM next-state and per-cycle control strobes
    always_comb begin
        w_state_nx   = r_state;
        w_rd_fire    = 1'b0;
        w_load_first = 1'b0;
        w_next_pass  = 1'b0;
        w_busy_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_busy_set = 1'b1;
                    if (N_QUBITS >= 2) begin
                        w_load_first = 1'b1;
                        w_state_nx   = S_ISSUE;
                    end else begin
                        w_state_nx   = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                w_rd_fire = w_hit;
                if (&r_i) w_state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                // leave in the cycle of the last write-back of the pass
                if (w_cnt_nx == '0) begin
                    w_next_pass = 1'b1;
                    w_state_nx  = w_more ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // index and pair counters; r_i wraps back to 0 at the end of each pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (w_load_first) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= QW'(1);
        end else if (w_next_pass) begin
            r_i <= '0;
            r_j <= w_j_nx;
            r_k <= w_k_nx;
        end else if (r_state == S_ISSUE) begin
            r_i <= r_i + N_QUBITS'(1);
        end
    end

    // ---- issue stage -> gate input stage: angle aligned with read data ----
    // angle register, held between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_theta <= '0;
        else if (w_rd_fire) r_theta <= theta_for(r_j, r_k);
    end

    // ---- tag delay line: memory read cycle plus CROT_LAT gate stages ----
    // write-back tags travel alongside the amplitudes inside the gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_vld <= '0;
            for (int s = 0; s <= CROT_LAT; s++) r_dl_addr[s] <= '0;
        end else begin
            r_dl_vld     <= {r_dl_vld[CROT_LAT-1:0], w_rd_fire};
            r_dl_addr[0] <= r_i;
            for (int s = 1; s <= CROT_LAT; s++) r_dl_addr[s] <= r_dl_addr[s-1];
        end
    end

    // in-flight count: reads issued but not yet written back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= w_cnt_nx;
    end

    // busy/done flags; busy drops in the same cycle done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (w_busy_set)              r_busy <= 1'b1;
            else if (r_state == S_DONE)  r_busy <= 1'b0;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.mem_rd_en   = w_rd_fire;
    assign bus.mem_rd_addr = r_i;
    assign bus.crot_in_r   = bus.mem_rd_r;
    assign bus.crot_in_i   = bus.mem_rd_i;
    assign bus.crot_theta  = r_theta;
    assign bus.mem_wr_en   = w_wr_fire;
    assign bus.mem_wr_addr = r_dl_addr[CROT_LAT];
    assign bus.mem_wr_r    = bus.crot_out_r;
    assign bus.mem_wr_i    = bus.crot_out_i;
endmodule
